mem_wb_stage: RTL

Parametrised memory stage plus MEM/WB pipeline register for the pipelined RISC-V core. It issues loads and stores to a data-memory bus using a valid/ready request and response handshake, and stalls upstream stages while an access is outstanding. It aligns and sign-/zero-extends load data per funct3, generates store byte enables, and supports pipeline flush. It also registers instruction-valid into WB, so there is no combinational pass-through.

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/lsu_align.sv | 61 ++++++
 rtl/mem_wb_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MEM/WB stage of the pipelined RISC-V core.
//   funct3_e       : load/store size and signedness encoding (funct3)
//   state_e        : memory-access FSM states
//   size_log2()    : funct3 -> log2(access bytes), XLEN-aware
//   is_unsigned()  : funct3 -> zero-extend on load
//   size_to_mask() : log2(bytes) -> unshifted byte-enable mask
//   *_DEF          : byte-enable / offset widths for the default XLEN of 32
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int BE_W_DEF  = XLEN_DEF / 8;
  localparam int OFF_W_DEF = $clog2(BE_W_DEF);

  // Doubleword only exists on RV64; on RV32 it collapses to a word access.
  function automatic logic [1:0] size_log2(input logic [2:0] f3, input logic is64);
    logic [1:0] sz;
    case (f3)
      F3_B, F3_BU: sz = 2'd0;
      F3_H, F3_HU: sz = 2'd1;
      F3_D:        sz = is64 ? 2'd3 : 2'd2;
      default:     sz = 2'd2;
    endcase
    return sz;
  endfunction

  // WU is a signed word on RV32; extension is a no-op there anyway.
  function automatic logic is_unsigned(input logic [2:0] f3, input logic is64);
    return (f3 == F3_BU) || (f3 == F3_HU) || ((f3 == F3_WU) && is64);
  endfunction

  function automatic logic [7:0] size_to_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational data alignment for the load/store unit.
//   i_funct3     : access size/sign
//   i_off        : byte offset of the access inside the bus word
//   i_store_data : rs2 store data (lane 0)
//   i_rsp_rdata  : raw bus word returned by a load
//   o_wdata      : store data shifted to its byte lane
//   o_be         : byte enables for the store
//   o_rdata      : load data extracted and sign/zero-extended to XLEN
// The offset is rounded down to the natural alignment of the access size, so
// an unaligned offset never produces enables that straddle the bus word.
// ---------------------------------------------------------------------------
module lsu_align
  import mem_pkg::*;
#(
  parameter int  XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [2:0]       i_funct3,
  input  logic [OFF_W-1:0] i_off,
  input  logic [XLEN-1:0]  i_store_data,
  input  logic [XLEN-1:0]  i_rsp_rdata,
  output logic [XLEN-1:0]  o_wdata,
  output logic [BE_W-1:0]  o_be,
  output logic [XLEN-1:0]  o_rdata
);

  localparam logic IS64 = (XLEN == 64);

  logic [1:0]       w_size;
  logic             w_unsigned;
  logic [OFF_W-1:0] w_lo_mask;
  logic [OFF_W-1:0] w_off_al;
  logic [6:0]       w_byte_bits;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_keep;
  logic [XLEN-1:0]  w_sign_mask;
  logic             w_sign;

  assign w_size     = size_log2(i_funct3, IS64);
  assign w_unsigned = is_unsigned(i_funct3, IS64);
  assign w_lo_mask  = OFF_W'((4'd1 << w_size) - 4'd1);
  assign w_off_al   = i_off & ~w_lo_mask;

  // Store path
  assign o_wdata = i_store_data << {w_off_al, 3'b000};
  assign o_be    = BE_W'(size_to_mask(w_size)) << w_off_al;

  // Load path: move the addressed lane to bit 0, keep `size` bytes, then
  // fill the upper bits with either the lane's MSB or zeros. A full-width
  // access shifts the all-ones pattern out entirely, so w_keep is all ones.
  assign w_shifted   = i_rsp_rdata >> {w_off_al, 3'b000};
  assign w_byte_bits = 7'd8 << w_size;
  assign w_keep      = ~({XLEN{1'b1}} << w_byte_bits);
  assign w_sign_mask = {{(XLEN-1){1'b0}}, 1'b1} << (w_byte_bits - 7'd1);
  assign w_sign      = (|(w_shifted & w_sign_mask)) & ~w_unsigned;
  assign o_rdata     = (w_shifted & w_keep) | ({XLEN{w_sign}} & ~w_keep);

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory stage plus MEM/WB pipeline register. Issues loads/stores on a
// valid/ready request + response bus, stalls upstream while an access is in
// flight, and registers everything going to WB (no combinational bypass).
//
// Optional macro MEM_MISALIGN_CHK_EN: when defined, accesses whose offset is
// not a multiple of their size are not issued and are flagged in
// o_misalign_w; when undefined the offset is rounded down and issued.
//
// Ports
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_*_m                   : MEM-stage instruction fields
//   o_stall_m               : hold IF/ID/EX/MEM (combinational)
//   o_dmem_req_*            : data-memory request (valid/ready)
//   i_dmem_rsp_*            : data-memory load response
//   o_*_w                   : registered WB-stage fields
// ---------------------------------------------------------------------------
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  RA_W  = 5,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid_m,
  input  logic            i_flush_m,
  input  logic            i_reg_write_m,
  input  logic            i_mem_read_m,
  input  logic            i_mem_write_m,
  input  logic [2:0]      i_funct3_m,
  input  logic [1:0]      i_result_src_m,
  input  logic [RA_W-1:0] i_rd_addr_m,
  input  logic [XLEN-1:0] i_pc_plus4_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_store_data_m,
  output logic            o_stall_m,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  output logic            o_dmem_req_we,
  output logic [XLEN-1:0] o_dmem_req_addr,
  output logic [XLEN-1:0] o_dmem_req_wdata,
  output logic [BE_W-1:0] o_dmem_req_be,
  input  logic            i_dmem_rsp_valid,
  input  logic [XLEN-1:0] i_dmem_rsp_rdata,
  output logic            o_valid_w,
  output logic            o_reg_write_w,
  output logic [1:0]      o_result_src_w,
  output logic [RA_W-1:0] o_rd_addr_w,
  output logic [XLEN-1:0] o_pc_plus4_w,
  output logic [XLEN-1:0] o_alu_result_w,
  output logic [XLEN-1:0] o_read_data_w,
  output logic            o_misalign_w
);

  state_e          r_state;
  state_e          w_state_next;
  logic            r_flush_seen;
  logic            r_valid_w;
  logic            r_reg_write_w;
  logic [1:0]      r_result_src_w;
  logic [RA_W-1:0] r_rd_addr_w;
  logic [XLEN-1:0] r_pc_plus4_w;
  logic [XLEN-1:0] r_alu_result_w;
  logic [XLEN-1:0] r_read_data_w;
  logic            r_misalign_w;

  logic            w_access;
  logic            w_misalign;
  logic            w_mem_op;
  logic            w_req_valid;
  logic            w_pending;
  logic            w_done;
  logic            w_stall;
  logic            w_kill;
  logic            w_valid_next;
  logic            w_load_done;
  logic [XLEN-1:0] w_load_data;

  assign w_access = i_valid_m & ~i_flush_m & (i_mem_read_m | i_mem_write_m);

`ifdef MEM_MISALIGN_CHK_EN
  logic [1:0]       w_size_chk;
  logic [OFF_W-1:0] w_lo_mask_chk;
  assign w_size_chk    = size_log2(i_funct3_m, XLEN == 64);
  assign w_lo_mask_chk = OFF_W'((4'd1 << w_size_chk) - 4'd1);
  assign w_misalign    = w_access & (|(i_alu_result_m[OFF_W-1:0] & w_lo_mask_chk));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_mem_op = w_access & ~w_misalign;

  lsu_align #(
    .XLEN (XLEN)
  ) u_lsu_align (
    .i_funct3     (i_funct3_m),
    .i_off        (i_alu_result_m[OFF_W-1:0]),
    .i_store_data (i_store_data_m),
    .i_rsp_rdata  (i_dmem_rsp_rdata),
    .o_wdata      (o_dmem_req_wdata),
    .o_be         (o_dmem_req_be),
    .o_rdata      (w_load_data)
  );

  // A mem_op is "pending" from the cycle it appears until its completion
  // cycle; w_done marks completion (store accepted or load response seen).
  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    w_pending    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_req_valid = 1'b1;
          w_pending   = 1'b1;
          if (i_dmem_req_ready) begin
            if (i_mem_read_m) w_state_next = ST_WAIT_RSP;
            else              w_done       = 1'b1;
          end else begin
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A flush here does not retract the request once valid is up.
        w_req_valid = 1'b1;
        w_pending   = 1'b1;
        if (i_dmem_req_ready) begin
          if (i_mem_read_m) begin
            w_state_next = ST_WAIT_RSP;
          end else begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_RSP: begin
        w_pending = 1'b1;
        if (i_dmem_rsp_valid) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_stall = w_pending & ~w_done;

  // Gate with reset so the bus and upstream see an idle stage while reset is
  // held, even though MEM inputs may still be asserted.
  assign o_stall_m        = w_stall & i_rst_n;
  assign o_dmem_req_valid = w_req_valid & i_rst_n;
  assign o_dmem_req_we    = i_mem_write_m & ~i_mem_read_m;
  assign o_dmem_req_addr  = {i_alu_result_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  // A flush seen after the request went out turns the completion into a bubble.
  assign w_kill       = i_flush_m | r_flush_seen;
  assign w_valid_next = i_valid_m & ~w_kill & ~w_stall;
  assign w_load_done  = w_done & (r_state == ST_WAIT_RSP) & ~w_kill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_flush_seen   <= 1'b0;
      r_valid_w      <= 1'b0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_addr_w    <= '0;
      r_pc_plus4_w   <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_misalign_w   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_flush_seen   <= (w_state_next != ST_IDLE) &
                        (r_flush_seen | (i_flush_m & (r_state != ST_IDLE)));
      r_valid_w      <= w_valid_next;
      r_reg_write_w  <= i_reg_write_m & w_valid_next & ~w_misalign;
      r_result_src_w <= i_result_src_m;
      r_rd_addr_w    <= i_rd_addr_m;
      r_pc_plus4_w   <= i_pc_plus4_m;
      r_alu_result_w <= i_alu_result_m;
      r_misalign_w   <= w_misalign;
      if (w_load_done) r_read_data_w <= w_load_data;
    end
  end

  assign o_valid_w      = r_valid_w;
  assign o_reg_write_w  = r_reg_write_w;
  assign o_result_src_w = r_result_src_w;
  assign o_rd_addr_w    = r_rd_addr_w;
  assign o_pc_plus4_w   = r_pc_plus4_w;
  assign o_alu_result_w = r_alu_result_w;
  assign o_read_data_w  = r_read_data_w;
  assign o_misalign_w   = r_misalign_w;

endmodule
